// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of two master ports and the RAM port around mem_arbiter.
// slave = arbiter side, master = masters/RAM side.
interface mem_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 8
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_lock;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_lock;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_o_data;
  logic          mem_wr;
  logic [DW-1:0] mem_i_data;

  logic          busy;
  logic          grant;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_ack, m1_rdata,
    output mem_address, mem_o_data, mem_wr,
    input  mem_i_data,
    output busy, grant
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_ack, m1_rdata,
    input  mem_address, mem_o_data, mem_wr,
    output mem_i_data,
    input  busy, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter onto a byte-wide RAM with lock.
// Ports: clk, reset (async high), bus (m0_*, m1_*, mem_*, busy, grant).
module mem_arbiter #(
  parameter int AW       = 20,
  parameter int DW       = 8,
  parameter int READ_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          busy_q, busy_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          lock_q, lock_d;

  logic hold_req;
  logic locked;
  logic cand0;
  logic cand1;
  logic pick;
  logic pick_we;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant_d  = grant_q;
    last_d   = last_q;
    lock_d   = lock_q;

    // The lock only shields the holder while it keeps requesting.
    hold_req = grant_q ? bus.m1_req : bus.m0_req;
    locked   = lock_q & hold_req;
    cand0    = bus.m0_req & ~(locked & grant_q);
    cand1    = bus.m1_req & ~(locked & ~grant_q);
    pick     = (cand0 & cand1) ? ~last_q : cand1;
    pick_we  = pick ? bus.m1_we : bus.m0_we;

    unique case (state_q)
      IDLE: begin
        if (lock_q && !hold_req) lock_d = 1'b0;
        if (cand0 || cand1) begin
          addr_d  = pick ? bus.m1_addr : bus.m0_addr;
          wdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
          grant_d = pick;
          last_d  = pick;
          if (pick_we) begin
            state_d = WR;
            wr_d    = 1'b1;
          end else begin
            state_d = RD;
            cnt_d   = '0;
          end
        end
      end
      WR: begin
        state_d = DONE;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
      end
      RD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(READ_LAT)) begin
          if (grant_q) rdata1_d = bus.mem_i_data;
          else         rdata0_d = bus.mem_i_data;
          state_d = DONE;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
        end
      end
      DONE: begin
        lock_d  = grant_q ? bus.m1_lock : bus.m0_lock;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      lock_q   <= lock_d;
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_o_data  = wdata_q;
  assign bus.mem_wr      = wr_q;
  assign bus.m0_ack      = ack0_q;
  assign bus.m1_ack      = ack1_q;
  assign bus.m0_rdata    = rdata0_q;
  assign bus.m1_rdata    = rdata1_q;
  assign bus.busy        = busy_q;
  assign bus.grant       = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter (READ_LAT 2 and 3 instances).
// Behavioural RAM models with registered read pipelines sit on the RAM ports.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(20), .DW(8)) b0 ();
  mem_arbiter_if #(.AW(20), .DW(8)) b1 ();

  mem_arbiter #(.AW(20), .DW(8), .READ_LAT(2)) dut0 (
    .clk(clk), .reset(rst), .bus(b0)
  );
  mem_arbiter #(.AW(20), .DW(8), .READ_LAT(3)) dut1 (
    .clk(clk), .reset(rst), .bus(b1)
  );

  logic [7:0]  ram0 [0:1048575];
  logic [7:0]  ram1 [0:1048575];
  logic [7:0]  p0a, p0b, p1a, p1b, p1c;
  logic        pl_en = 1'b0;
  logic        pl_sel;
  logic [19:0] pl_a;
  logic [7:0]  pl_d;

  always @(posedge clk) begin
    if (b0.mem_wr) ram0[b0.mem_address] <= b0.mem_o_data;
    if (b1.mem_wr) ram1[b1.mem_address] <= b1.mem_o_data;
    if (pl_en && !pl_sel) ram0[pl_a] <= pl_d;
    if (pl_en && pl_sel) ram1[pl_a] <= pl_d;
    p0a <= ram0[b0.mem_address];
    p0b <= p0a;
    p1a <= ram1[b1.mem_address];
    p1b <= p1a;
    p1c <= p1b;
  end

  assign b0.mem_i_data = p0b;
  assign b1.mem_i_data = p1c;

  task automatic preload(input bit sel, input logic [19:0] a,
                         input logic [7:0] d);
    pl_sel = sel;
    pl_a   = a;
    pl_d   = d;
    pl_en  = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic drop_all();
    b0.m0_req = 0; b0.m1_req = 0;
    b1.m0_req = 0; b1.m1_req = 0;
  endtask

  task automatic do_reset();
    drop_all();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One access on dut0; lat counts cycles from the sampling IDLE cycle.
  task automatic access0(
    input bit p, input bit we, input logic [19:0] a,
    input logic [7:0] wd, input bit lk, input bit keep,
    output int lat, output logic [7:0] rd,
    output int wrc, output int oth
  );
    if (!p) begin
      b0.m0_req = 1; b0.m0_we = we; b0.m0_addr = a;
      b0.m0_wdata = wd; b0.m0_lock = lk;
    end else begin
      b0.m1_req = 1; b0.m1_we = we; b0.m1_addr = a;
      b0.m1_wdata = wd; b0.m1_lock = lk;
    end
    lat = 0; wrc = 0; oth = 0; rd = '0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (b0.mem_wr) wrc++;
      if (p ? b0.m0_ack : b0.m1_ack) oth++;
      if (p ? b0.m1_ack : b0.m0_ack) begin
        rd = p ? b0.m1_rdata : b0.m0_rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      if (!p) b0.m0_req = 0;
      else    b0.m1_req = 0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++;
    if (b0.busy !== 0 || b0.mem_wr !== 0) begin
      nerr++;
      $display("FAIL reset_busy_wr: busy=%b wr=%b want 0 0", b0.busy, b0.mem_wr);
    end
    nvec++;
    if (b0.m0_ack !== 0 || b0.m1_ack !== 0) begin
      nerr++;
      $display("FAIL reset_ack: got %b%b want 00", b0.m0_ack, b0.m1_ack);
    end
    nvec++;
    if (b0.mem_address !== 0 || b0.mem_o_data !== 0) begin
      nerr++;
      $display("FAIL reset_mem: addr=%h data=%h want 0 0",
               b0.mem_address, b0.mem_o_data);
    end
    nvec++;
    if (b0.m0_rdata !== 0 || b0.m1_rdata !== 0 || b0.grant !== 0) begin
      nerr++;
      $display("FAIL reset_rd_gnt: r0=%h r1=%h g=%b want 0 0 0",
               b0.m0_rdata, b0.m1_rdata, b0.grant);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_m0();
    int lat, wrc, oth;
    logic [7:0] rd;
    preload(0, 20'h00010, 8'hA5);
    access0(0, 0, 20'h00010, 8'h00, 0, 0, lat, rd, wrc, oth);
    nvec++;
    if (lat !== 4) begin
      nerr++; $display("FAIL m0_read_lat: got %0d want 4", lat);
    end
    nvec++;
    if (rd !== 8'hA5) begin
      nerr++; $display("FAIL m0_read_data: got %h want a5", rd);
    end
    nvec++;
    if (oth !== 0 || wrc !== 0 || b0.grant !== 0) begin
      nerr++;
      $display("FAIL m0_read_side: m1ack=%0d wr=%0d g=%b want 0 0 0",
               oth, wrc, b0.grant);
    end
  endtask

  task automatic test_write_read_m1();
    int lat, wrc, oth;
    logic [7:0] rd;
    access0(1, 1, 20'hFFFFF, 8'h3C, 0, 0, lat, rd, wrc, oth);
    nvec++;
    if (lat !== 2) begin
      nerr++; $display("FAIL m1_write_lat: got %0d want 2", lat);
    end
    nvec++;
    if (wrc !== 1 || oth !== 0) begin
      nerr++; $display("FAIL m1_write_wr: wr=%0d m0ack=%0d want 1 0", wrc, oth);
    end
    nvec++;
    if (ram0[20'hFFFFF] !== 8'h3C) begin
      nerr++; $display("FAIL m1_write_ram: got %h want 3c", ram0[20'hFFFFF]);
    end
    access0(1, 0, 20'hFFFFF, 8'h00, 0, 0, lat, rd, wrc, oth);
    nvec++;
    if (lat !== 4 || rd !== 8'h3C) begin
      nerr++; $display("FAIL m1_read: lat=%0d d=%h want 4 3c", lat, rd);
    end
    nvec++;
    if (b0.m0_rdata !== 8'hA5 || b0.grant !== 1) begin
      nerr++;
      $display("FAIL m1_side: r0=%h g=%b want a5 1", b0.m0_rdata, b0.grant);
    end
  endtask

  task automatic test_round_robin();
    int seq [4];
    int n;
    logic [7:0] d0, d1;
    do_reset();
    preload(0, 20'h00300, 8'h11);
    preload(0, 20'h00301, 8'h22);
    b0.m0_we = 0; b0.m0_addr = 20'h00300; b0.m0_lock = 0;
    b0.m1_we = 0; b0.m1_addr = 20'h00301; b0.m1_lock = 0;
    b0.m0_req = 1; b0.m1_req = 1;
    n = 0; d0 = '0; d1 = '0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (b0.m0_ack && n < 4) begin seq[n] = 0; d0 = b0.m0_rdata; n++; end
      if (b0.m1_ack && n < 4) begin seq[n] = 1; d1 = b0.m1_rdata; n++; end
    end
    b0.m0_req = 0; b0.m1_req = 0;
    nvec++;
    if (n !== 4) begin
      nerr++; $display("FAIL rr_count: got %0d acks want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (i < n && seq[i] !== (i % 2)) begin
        nerr++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, seq[i], i % 2);
      end
    end
    nvec++;
    if (d0 !== 8'h11 || d1 !== 8'h22) begin
      nerr++; $display("FAIL rr_data: got %h %h want 11 22", d0, d1);
    end
  endtask

  task automatic test_lock();
    int lat, wrc, oth, m1lat;
    bit got;
    logic [7:0] rd;
    do_reset();
    preload(0, 20'h00200, 8'h5A);
    preload(0, 20'h00100, 8'h42);
    b0.m1_we = 0; b0.m1_addr = 20'h00200; b0.m1_lock = 0; b0.m1_req = 1;
    access0(0, 0, 20'h00100, 8'h00, 1, 1, lat, rd, wrc, oth);
    nvec++;
    if (lat !== 4 || rd !== 8'h42 || oth !== 0) begin
      nerr++;
      $display("FAIL lock_read: lat=%0d d=%h m1ack=%0d want 4 42 0", lat, rd, oth);
    end
    access0(0, 1, 20'h00100, 8'h77, 0, 0, lat, rd, wrc, oth);
    nvec++;
    if (lat !== 2 || oth !== 0 || wrc !== 1) begin
      nerr++;
      $display("FAIL lock_write: lat=%0d m1ack=%0d wr=%0d want 2 0 1",
               lat, oth, wrc);
    end
    nvec++;
    if (ram0[20'h00100] !== 8'h77) begin
      nerr++; $display("FAIL lock_ram: got %h want 77", ram0[20'h00100]);
    end
    m1lat = 0; got = 0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m1lat++;
      if (b0.m1_ack) begin got = 1; break; end
    end
    nvec++;
    if (!got || m1lat !== 4 || b0.m1_rdata !== 8'h5A) begin
      nerr++;
      $display("FAIL lock_m1_after: lat=%0d d=%h want 4 5a", m1lat, b0.m1_rdata);
    end
    @(posedge clk);
    #1 b0.m1_req = 0;
  endtask

  task automatic test_reset_mid_read();
    int acks;
    for (int i = 0; i < 20 && b0.busy; i++) @(negedge clk);
    preload(0, 20'h00400, 8'h99);
    b0.m0_we = 0; b0.m0_addr = 20'h00400; b0.m0_lock = 0; b0.m0_req = 1;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (b0.busy !== 1) begin
      nerr++; $display("FAIL mid_busy_before: got %b want 1", b0.busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    nvec++;
    if (b0.busy !== 0 || b0.mem_wr !== 0 || b0.mem_address !== 0) begin
      nerr++;
      $display("FAIL mid_reset_out: busy=%b wr=%b a=%h want 0 0 0",
               b0.busy, b0.mem_wr, b0.mem_address);
    end
    b0.m0_req = 0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (b0.m0_ack || b0.m1_ack) acks++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (b0.m0_ack || b0.m1_ack) acks++;
    end
    nvec++;
    if (acks !== 0 || b0.m0_rdata !== 0) begin
      nerr++;
      $display("FAIL mid_no_ack: acks=%0d r0=%h want 0 0", acks, b0.m0_rdata);
    end
    b0.m1_we = 0; b0.m1_addr = 20'h00010; b0.m1_lock = 0;
    b0.m0_req = 1; b0.m1_req = 1;
    @(posedge clk);
    #1;
    nvec++;
    if (b0.grant !== 0 || b0.busy !== 1) begin
      nerr++;
      $display("FAIL mid_first_tie: g=%b busy=%b want 0 1", b0.grant, b0.busy);
    end
    b0.m0_req = 0; b0.m1_req = 0;
    for (int i = 0; i < 20 && b0.busy; i++) @(negedge clk);
  endtask

  task automatic test_read_lat3();
    int lat;
    bit got;
    preload(1, 20'h01234, 8'h5E);
    b1.m0_we = 0; b1.m0_addr = 20'h01234; b1.m0_lock = 0; b1.m0_req = 1;
    lat = 0; got = 0;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (b1.m0_ack) begin got = 1; break; end
    end
    nvec++;
    if (!got || lat !== 5) begin
      nerr++; $display("FAIL lat3_ack: got %0d want 5", lat);
    end
    nvec++;
    if (b1.m0_rdata !== 8'h5E) begin
      nerr++; $display("FAIL lat3_data: got %h want 5e", b1.m0_rdata);
    end
    @(posedge clk);
    #1 b1.m0_req = 0;
  endtask

  initial begin
    rst = 1'b1;
    b0.m0_req = 0; b0.m0_we = 0; b0.m0_addr = '0; b0.m0_wdata = '0; b0.m0_lock = 0;
    b0.m1_req = 0; b0.m1_we = 0; b0.m1_addr = '0; b0.m1_wdata = '0; b0.m1_lock = 0;
    b1.m0_req = 0; b1.m0_we = 0; b1.m0_addr = '0; b1.m0_wdata = '0; b1.m0_lock = 0;
    b1.m1_req = 0; b1.m1_we = 0; b1.m1_addr = '0; b1.m1_wdata = '0; b1.m1_lock = 0;
    test_reset();
    test_read_m0();
    test_write_read_m1();
    test_round_robin();
    test_lock();
    test_reset_mid_read();
    test_read_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
